// File: rtl/dram_read_streamer.sv
// rtl/dram_read_streamer.sv - credit-gated 16-beat AXI burst reader feeding a beat FIFO
module dram_read_streamer #(
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        IP_CLK,
    input  logic        IP_RESET,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] length,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [32:0] IP_MAXI0_ARADDR,
    input  logic        IP_MAXI0_ARADDR_ready,
    output logic [3:0]  IP_MAXI0_ARLEN,
    output logic [1:0]  IP_MAXI0_ARSIZE,
    output logic [1:0]  IP_MAXI0_ARBURST,
    input  logic [64:0] IP_MAXI0_RDATA,
    output logic        IP_MAXI0_RDATA_ready,
    input  logic [1:0]  IP_MAXI0_RRESP,
    input  logic        IP_MAXI0_RLAST,
    output logic [64:0] out,
    input  logic        out_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [24:0]   bursts_q, bursts_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [3:0]    beat_q, beat_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic [15:0] pending_w;
    logic [15:0] credits_w;
    logic        arvalid_w;
    logic        ar_fire_w;
    logic        r_fire_w;
    logic        last_beat_w;
    logic        out_valid_w;
    logic        pop_w;
    logic        unused_bits;

    // The low 7 address/length bits are intentionally dropped (128-byte granularity).
    assign unused_bits = ^{base_addr[6:0], length[6:0]};

    // Beats still owed by DRAM for bursts already issued; each one already owns a FIFO slot.
    assign pending_w = (16'(outst_q) << 4) - 16'(beat_q);
    assign credits_w = 16'(FIFO_DEPTH) - 16'(count_q) - pending_w;

    // Once raised, ARVALID cannot drop before ARREADY: credits never shrink without an issue.
    assign arvalid_w = (state_q == S_ISSUE) && (bursts_q != 25'd0) &&
                       (outst_q < OW'(MAX_OUTSTANDING)) && (credits_w >= 16'd16);
    assign ar_fire_w   = arvalid_w && IP_MAXI0_ARADDR_ready;
    assign IP_MAXI0_RDATA_ready = (outst_q != '0);
    assign r_fire_w    = IP_MAXI0_RDATA[64] && IP_MAXI0_RDATA_ready;
    assign last_beat_w = (beat_q == 4'd15);
    assign out_valid_w = (count_q != '0);
    assign pop_w       = out_valid_w && out_ready;

    assign IP_MAXI0_ARADDR  = {arvalid_w, addr_q};
    assign IP_MAXI0_ARLEN   = 4'd15;
    assign IP_MAXI0_ARSIZE  = 2'b11;
    assign IP_MAXI0_ARBURST = 2'b01;
    assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done = done_q;
    assign err  = err_q;
    assign out  = {out_valid_w, out_valid_w ? mem_q[rd_ptr_q] : 64'd0};

    // Transfer sequencing, AR issue bookkeeping and R-beat accounting.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        bursts_d = bursts_q;
        outst_d  = outst_q;
        beat_d   = beat_q;
        err_d    = err_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = {base_addr[31:7], 7'd0};
                    bursts_d = length[31:7];
                    err_d    = 1'b0;
                    done_d   = 1'b0;
                    state_d  = (length[31:7] == 25'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_fire_w) begin
                    addr_d   = addr_q + 32'd128;
                    bursts_d = bursts_q - 25'd1;
                    if (bursts_q == 25'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((outst_q == '0) && (count_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (r_fire_w) begin
            beat_d = beat_q + 4'd1;
            if ((IP_MAXI0_RRESP != 2'b00) || (IP_MAXI0_RLAST != last_beat_w)) begin
                err_d = 1'b1;
            end
        end
        if (ar_fire_w && !(r_fire_w && last_beat_w)) begin
            outst_d = outst_q + OW'(1);
        end else if (!ar_fire_w && r_fire_w && last_beat_w) begin
            outst_d = outst_q - OW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge IP_CLK) begin
        if (IP_RESET) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            bursts_q <= 25'd0;
            outst_q  <= '0;
            beat_q   <= 4'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            bursts_q <= bursts_d;
            outst_q  <= outst_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Beat FIFO pointers and occupancy; a write into a full FIFO means credit accounting broke.
    always_ff @(posedge IP_CLK) begin
        if (IP_RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(r_fire_w && (count_q == (PW + 1)'(FIFO_DEPTH))));
            if (r_fire_w) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (r_fire_w && !pop_w) begin
                count_q <= count_q + (PW + 1)'(1);
            end else if (!r_fire_w && pop_w) begin
                count_q <= count_q - (PW + 1)'(1);
            end
        end
    end

    // Beat storage, written on every accepted R beat.
    always_ff @(posedge IP_CLK) begin
        if (r_fire_w) begin
            mem_q[wr_ptr_q] <= IP_MAXI0_RDATA[63:0];
        end
    end

endmodule

// File: tb/tb_dram_read_streamer.sv
// tb/tb_dram_read_streamer.sv - scoreboard bench with DRAM slave model for dram_read_streamer
module tb_dram_read_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] length;
    logic        busy, done, err;
    logic [32:0] araddr;
    logic        arready;
    logic [3:0]  arlen;
    logic [1:0]  arsize, arburst;
    logic [64:0] rdata;
    logic        rready;
    logic [1:0]  rresp;
    logic        rlast;
    logic [64:0] out;
    logic        out_ready;

    always #5 clk = ~clk;

    dram_read_streamer #(.FIFO_DEPTH(64), .MAX_OUTSTANDING(4)) dut (
        .IP_CLK(clk),
        .IP_RESET(rst),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .err(err),
        .IP_MAXI0_ARADDR(araddr),
        .IP_MAXI0_ARADDR_ready(arready),
        .IP_MAXI0_ARLEN(arlen),
        .IP_MAXI0_ARSIZE(arsize),
        .IP_MAXI0_ARBURST(arburst),
        .IP_MAXI0_RDATA(rdata),
        .IP_MAXI0_RDATA_ready(rready),
        .IP_MAXI0_RRESP(rresp),
        .IP_MAXI0_RLAST(rlast),
        .out(out),
        .out_ready(out_ready)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_ar_q[$];
    logic [63:0] exp_data_q[$];
    logic [31:0] ar_q[$];
    int          ar_count = 0;
    int          beat = 0;
    int          r_burst_idx = 0;
    bit          r_pending = 1'b0;
    bit          flush = 1'b1;
    bit          r_hold = 1'b0;
    bit          out_hold = 1'b0;
    bit          out_rand = 1'b1;
    bit          inj_rresp = 1'b0;
    bit          inj_rlast = 1'b0;
    int          inj_burst = 0;
    int          inj_beat = 0;
    logic [31:0] salt = 32'h0;
    bit          prev_arv = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] sl_a;

    function automatic logic [63:0] beat_data(input logic [31:0] a, input logic [31:0] s);
        return {a, a ^ s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // DRAM slave (AR + R) and output-stream scoreboard monitor.
    always @(negedge clk) begin
        if (flush) begin
            ar_q.delete();
            beat = 0;
            r_pending = 1'b0;
            rdata = 65'd0;
            rresp = 2'b00;
            rlast = 1'b0;
            arready = 1'b0;
            prev_arv = 1'b0;
            out_ready = 1'b0;
        end else begin
            check("rready_vs_outstanding", rready, ar_q.size() > 0);
            if (!r_pending) begin
                if (ar_q.size() > 0 && !r_hold && $urandom_range(0, 3) != 0) begin
                    sl_a  = ar_q[0] + 32'(beat * 8);
                    rdata = {1'b1, beat_data(sl_a, salt)};
                    rresp = (inj_rresp && r_burst_idx == inj_burst && beat == inj_beat) ? 2'b10 : 2'b00;
                    rlast = (beat == 15) ^ (inj_rlast && r_burst_idx == inj_burst && beat == 15);
                    r_pending = 1'b1;
                end else begin
                    rdata = 65'd0;
                    rresp = 2'b00;
                    rlast = 1'b0;
                end
            end
            if (r_pending && rready) begin
                r_pending = 1'b0;
                beat++;
                if (beat == 16) begin
                    beat = 0;
                    void'(ar_q.pop_front());
                    r_burst_idx++;
                end
            end

            if (prev_arv) begin
                check("arvalid_held", araddr[32], 1'b1);
                check("araddr_held", araddr[31:0], prev_addr);
            end
            arready   = ($urandom_range(0, 2) != 0);
            prev_arv  = araddr[32] && !arready;
            prev_addr = araddr[31:0];
            if (araddr[32] && arready) begin
                ar_count++;
                ar_q.push_back(araddr[31:0]);
                if (exp_ar_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ar: got 0x%0h required none", araddr[31:0]);
                end else begin
                    check("ar_addr", araddr[31:0], exp_ar_q.pop_front());
                end
            end

            out_ready = out_hold ? 1'b0 : (out_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (out[64] && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got 0x%0h required none", out[63:0]);
                end else begin
                    check("out_data", out[63:0], exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush = 1'b1;
        rst = 1'b1;
        start = 1'b0;
        base_addr = 32'h0;
        length = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic expect_xfer(input logic [31:0] b, input logic [31:0] l);
        logic [31:0] a0;
        int n;
        a0 = b & 32'hFFFF_FF80;
        n = int'(l >> 7);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            a = a0 + 32'(k * 128);
            exp_ar_q.push_back(a);
            for (int i = 0; i < 16; i++) exp_data_q.push_back(beat_data(a + 32'(i * 8), salt));
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] l);
        base_addr = b;
        length = l;
        r_burst_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: done=%0b required 1 within %0d cycles", name, done, limit);
        end
    endtask

    task automatic run_xfer(input string name, input logic [31:0] b, input logic [31:0] l, input bit exp_err);
        salt = $urandom;
        expect_xfer(b, l);
        pulse_start(b, l);
        check({name, "_err_cleared"}, err, 1'b0);
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_first_arvalid"}, araddr[32], 1'b1);
        wait_done(name, 20000);
        check({name, "_err"}, err, exp_err);
        check({name, "_busy_end"}, busy, 1'b0);
        check({name, "_beats_left"}, exp_data_q.size(), 0);
        check({name, "_ars_left"}, exp_ar_q.size(), 0);
        tick();
        tick();
        check({name, "_done_persists"}, done, 1'b1);
    endtask

    initial begin
        int n0;
        int n;
        bit busy_seen;
        start = 1'b0;
        rst = 1'b1;
        base_addr = 32'h0;
        length = 32'h0;
        do_reset();

        check("rst_arvalid", araddr[32], 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_out_valid", out[64], 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("arlen", arlen, 4'd15);
        check("arsize", arsize, 2'b11);
        check("arburst", arburst, 2'b01);

        run_xfer("basic", 32'h1000_0005, 32'h180, 1'b0);

        n0 = ar_count;
        busy_seen = 1'b0;
        base_addr = 32'h4000_0000;
        length = 32'h7F;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_seen = busy_seen | busy;
        tick();
        busy_seen = busy_seen | busy;
        check("zero_len_done", done, 1'b1);
        check("zero_len_busy", busy_seen, 1'b0);
        check("zero_len_no_ar", ar_count - n0, 0);

        out_hold = 1'b1;
        salt = $urandom;
        expect_xfer(32'h2000_0000, 32'h400);
        n0 = ar_count;
        pulse_start(32'h2000_0000, 32'h400);
        repeat (300) tick();
        check("fc_ar_count", ar_count - n0, 4);
        check("fc_no_arvalid", araddr[32], 1'b0);
        check("fc_out_valid", out[64], 1'b1);
        check("fc_busy", busy, 1'b1);
        out_hold = 1'b0;
        wait_done("fc", 20000);
        check("fc_ar_total", ar_count - n0, 8);
        check("fc_beats_left", exp_data_q.size(), 0);

        inj_rresp = 1'b1;
        inj_burst = 1;
        inj_beat = 5;
        run_xfer("rresp_err", 32'h5000_0000, 32'h100, 1'b1);
        inj_rresp = 1'b0;

        run_xfer("wrap", 32'hFFFF_FF80, 32'h100, 1'b0);

        inj_rlast = 1'b1;
        inj_burst = 0;
        run_xfer("rlast_err", 32'h6000_0040, 32'h180, 1'b1);
        inj_rlast = 1'b0;

        r_hold = 1'b1;
        salt = $urandom;
        expect_xfer(32'h3000_0000, 32'h100);
        n0 = ar_count;
        pulse_start(32'h3000_0000, 32'h100);
        n = 0;
        while (ar_count - n0 < 2 && n < 500) begin
            tick();
            n++;
        end
        check("mid_rst_two_ars", ar_count - n0, 2);
        repeat (3) tick();
        check("mid_rst_busy_before", busy, 1'b1);
        check("mid_rst_rready_before", rready, 1'b1);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        check("mid_rst_arvalid", araddr[32], 1'b0);
        check("mid_rst_rready", rready, 1'b0);
        check("mid_rst_out_valid", out[64], 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        rst = 1'b0;
        exp_ar_q.delete();
        exp_data_q.delete();
        r_hold = 1'b0;
        tick();
        flush = 1'b0;
        run_xfer("post_rst", 32'h3000_0000, 32'h100, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int nb;
            nb = $urandom_range(1, 8);
            out_rand = (t % 2 == 0);
            run_xfer("rand", $urandom, 32'(nb * 128) + 32'($urandom_range(0, 127)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
